card_dealer: RTL

- Produces 4-bit card codes (0=A, 1..8 = 2..9, 9=10, 10=J, 11=Q, 12=K), the same encoding the card-value evaluator consumes.
- Models one 52-card deck (4 of each rank) without replacement. It picks ranks pseudo-randomly with a free-running LFSR and deals one card per draw request.
- Sits between the game FSM (issues draws and shuffles) and the player/dealer hand accumulators (consume o_Card on o_Valid).

---
 rtl/card_dealer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/card_dealer.sv
// card_dealer: deals 4-bit card codes (0=A .. 12=K) from a single deck
// without replacement. A free-running 8-bit LFSR proposes a rank; when that
// rank is exhausted the dealer walks upward (wrapping K -> A) to the next
// rank that still has cards.
//
// Handshake: i_Draw is a one-cycle request that is accepted only while
// o_Busy is low and o_Empty is low; a request seen at any other time is
// dropped, not queued. Each accepted request produces exactly one o_Valid
// pulse, and o_Card holds the dealt code from that pulse until the next deal.
// i_Shuffle refills the deck and cancels an accepted request, so that request
// then produces no pulse.
module card_dealer #(
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         CARDS_PER_RANK = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Draw,
  input  logic       i_Shuffle,
  output logic [3:0] o_Card,
  output logic       o_Valid,
  output logic       o_Busy,
  output logic       o_Empty,
  output logic [5:0] o_Remaining,
  output logic [1:0] o_Dbg_State
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_SCAN = 2'd2,
    ST_DEAL = 2'd3
  } state_e;

  localparam logic [2:0] FULL_CNT  = 3'(CARDS_PER_RANK);
  localparam logic [5:0] FULL_DECK = 6'(13 * CARDS_PER_RANK);

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] rank_q, rank_d;
  logic [2:0] cnt_q [13];
  logic [2:0] cnt_d [13];
  logic [5:0] rem_q, rem_d;
  logic [3:0] card_q, card_d;
  logic       valid_q, valid_d;
  logic       empty_q, empty_d;
  logic       busy_q, busy_d;

  logic [3:0] cand;
  logic       cand_avail;
  logic       rank_avail;

  // Rank successor with K -> A wrap.
  function automatic logic [3:0] next_rank(input logic [3:0] r);
    return (r == 4'd12) ? 4'd0 : r + 4'd1;
  endfunction

  // Fold the low LFSR nibble into 0..12 and look up card availability.
  always_comb begin
    cand       = (lfsr_q[3:0] < 4'd13) ? lfsr_q[3:0] : lfsr_q[3:0] - 4'd13;
    cand_avail = (cnt_q[cand] != 3'd0);
    rank_avail = (cnt_q[rank_q] != 3'd0);
  end

  // State and datapath registers; reset restores a fresh deck and the seed.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      rank_q  <= 4'd0;
      for (int i = 0; i < 13; i++) cnt_q[i] <= FULL_CNT;
      rem_q   <= FULL_DECK;
      card_q  <= 4'd0;
      valid_q <= 1'b0;
      empty_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rank_q  <= rank_d;
      for (int i = 0; i < 13; i++) cnt_q[i] <= cnt_d[i];
      rem_q   <= rem_d;
      card_q  <= card_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: shuffle overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (i_Shuffle) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (i_Draw && !empty_q) state_d = ST_PICK;
        ST_PICK: state_d = cand_avail ? ST_DEAL : ST_SCAN;
        ST_SCAN: state_d = rank_avail ? ST_DEAL : ST_SCAN;
        ST_DEAL: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath updates per state: rank search, dealing, deck bookkeeping.
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rank_d  = rank_q;
    for (int i = 0; i < 13; i++) cnt_d[i] = cnt_q[i];
    rem_d   = rem_q;
    card_d  = card_q;
    valid_d = 1'b0;
    empty_d = empty_q;
    if (i_Shuffle) begin
      for (int i = 0; i < 13; i++) cnt_d[i] = FULL_CNT;
      rem_d   = FULL_DECK;
      empty_d = 1'b0;
    end else begin
      case (state_q)
        ST_PICK: rank_d = cand_avail ? cand : next_rank(cand);
        ST_SCAN: if (!rank_avail) rank_d = next_rank(rank_q);
        ST_DEAL: begin
          card_d         = rank_q;
          valid_d        = 1'b1;
          cnt_d[rank_q]  = cnt_q[rank_q] - 3'd1;
          rem_d          = rem_q - 6'd1;
          empty_d        = (rem_q == 6'd1);
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Outputs come straight from registers.
  always_comb begin
    o_Card      = card_q;
    o_Valid     = valid_q;
    o_Busy      = busy_q;
    o_Empty     = empty_q;
    o_Remaining = rem_q;
    o_Dbg_State = state_q;
  end

endmodule
